// File: rtl/frame_capture_sram_ctrl_if.sv
// ============================================================================
// Module      : frame_capture_sram_ctrl_if
// Description : Pixel, host-handshake and SRAM pin bundle for the frame
//               capture controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface frame_capture_sram_ctrl_if #(
   parameter int ADDR_W = 20
) ();
   logic              cap_req;
   logic              cap_continuous;
   logic              frame_start;
   logic              pix_valid;
   logic [23:0]       pix_data;
   logic [ADDR_W-1:0] host_rd_addr;
   logic              host_done;
   logic [ADDR_W-1:0] sram_addr;
   logic [15:0]       sram_dq_out;
   logic              sram_we_n;
   logic              sram_ce_n;
   logic              sram_oe_n;
   logic              sram_lb_n;
   logic              sram_ub_n;
   logic              cap_busy;
   logic              frame_ready;
   logic [1:0]        ready_slot;
   logic              overflow_err;
   logic              short_frame_err;

   // Controller side
   modport slave (
      input  cap_req, cap_continuous, frame_start, pix_valid, pix_data,
             host_rd_addr, host_done,
      output sram_addr, sram_dq_out, sram_we_n, sram_ce_n, sram_oe_n,
             sram_lb_n, sram_ub_n, cap_busy, frame_ready, ready_slot,
             overflow_err, short_frame_err
   );

   // Video pipeline / host side
   modport master (
      output cap_req, cap_continuous, frame_start, pix_valid, pix_data,
             host_rd_addr, host_done,
      input  sram_addr, sram_dq_out, sram_we_n, sram_ce_n, sram_oe_n,
             sram_lb_n, sram_ub_n, cap_busy, frame_ready, ready_slot,
             overflow_err, short_frame_err
   );
endinterface

`default_nettype wire

// File: rtl/frame_capture_sram_ctrl.sv
// ============================================================================
// Module      : frame_capture_sram_ctrl
// Description : Captures 24-bit video frames into a ring of slots in 16-bit
//               async SRAM (2 pixels -> 3 words) and hands them to the host.
//               Optional macro MASK_WINDOW_EN blanks a rectangle of pixels.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module frame_capture_sram_ctrl #(
   parameter int H_ACTIVE    = 640,
   parameter int V_ACTIVE    = 480,
   parameter int ADDR_W      = 20,
   parameter int BASE_ADDR   = 0,
   parameter int FRAME_SLOTS = 1,
   parameter int FIFO_DEPTH  = 4,
   parameter int MASK_X0     = 516,
   parameter int MASK_X1     = 624,
   parameter int MASK_Y0     = 381,
   parameter int MASK_Y1     = 424
) (
   input  logic                         Main_CLK,
   input  logic                         Reset,
   frame_capture_sram_ctrl_if.slave     bus
);

   localparam int c_npix = H_ACTIVE * V_ACTIVE;
   localparam int c_xw   = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
   localparam int c_yw   = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
   localparam int c_aw   = $clog2(FIFO_DEPTH);

   localparam logic [ADDR_W-1:0] c_wpf    = ADDR_W'(c_npix * 3 / 2);
   localparam logic [ADDR_W-1:0] c_base   = ADDR_W'(BASE_ADDR);
   localparam logic [c_xw-1:0]   c_x_last = c_xw'(H_ACTIVE - 1);
   localparam logic [c_yw-1:0]   c_y_last = c_yw'(V_ACTIVE - 1);
   localparam logic [1:0]        c_slot_last = 2'(FRAME_SLOTS - 1);
   localparam logic [c_aw:0]     c_depth  = (c_aw + 1)'(FIFO_DEPTH);

   localparam logic [2:0] c_st_idle    = 3'd0;
   localparam logic [2:0] c_st_armed   = 3'd1;
   localparam logic [2:0] c_st_capture = 3'd2;
   localparam logic [2:0] c_st_drain   = 3'd3;
   localparam logic [2:0] c_st_handoff = 3'd4;

   logic [2:0]        r_state, w_state_next;

   logic [c_xw-1:0]   r_x;
   logic [c_yw-1:0]   r_y;
   logic              r_p_odd;
   logic [7:0]        r_hold_b;
   logic              r_pend;
   logic [15:0]       r_pend_word;
   logic [1:0]        r_slot;
   logic [1:0]        r_ready_slot;
   logic              r_overflow;
   logic              r_short_err;

   logic [15:0]       r_mem [FIFO_DEPTH];
   logic [c_aw-1:0]   r_wptr, r_rptr;
   logic [c_aw:0]     r_count;

   logic [ADDR_W-1:0] r_word_cnt;
   logic [ADDR_W-1:0] r_wr_addr;
   logic [15:0]       r_dq;
   logic              r_we_n;

   logic              w_cap_busy, w_frame_ready, w_wr_owns;
   logic              w_arm_cap, w_start, w_short, w_pix_acc, w_rearm, w_drain_done;
   logic              w_last_pix, w_flush, w_fifo_empty;
   logic              w_acc_a, w_acc_b, w_drop, w_pop;
   logic [c_aw:0]     w_space;
   logic [23:0]       w_pix;
   logic [15:0]       w_new_word;
   logic [ADDR_W-1:0] w_slot_base;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge Main_CLK or posedge Reset) begin
      if (Reset) r_state <= c_st_idle;
      else       r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         c_st_idle:    if (bus.cap_req)     w_state_next = c_st_armed;
         c_st_armed:   if (bus.frame_start) w_state_next = c_st_capture;
         c_st_capture: if (w_last_pix)      w_state_next = c_st_drain;
         c_st_drain:   if (w_fifo_empty && !r_pend) w_state_next = c_st_handoff;
         c_st_handoff: if (bus.host_done)
                          w_state_next = bus.cap_continuous ? c_st_armed : c_st_idle;
         default:      w_state_next = c_st_idle;
      endcase
   end

   always_comb begin
      w_cap_busy    = 1'b0;
      w_frame_ready = 1'b0;
      w_wr_owns     = 1'b0;
      w_arm_cap     = 1'b0;
      w_start       = 1'b0;
      w_short       = 1'b0;
      w_pix_acc     = 1'b0;
      w_rearm       = 1'b0;
      w_drain_done  = 1'b0;
      case (r_state)
         c_st_idle: w_arm_cap = bus.cap_req;
         c_st_armed: begin
            w_cap_busy = 1'b1;
            w_start    = bus.frame_start;
         end
         c_st_capture: begin
            w_cap_busy = 1'b1;
            w_wr_owns  = 1'b1;
            w_short    = bus.frame_start;
            w_pix_acc  = bus.pix_valid && !bus.frame_start;
         end
         c_st_drain: begin
            w_cap_busy   = 1'b1;
            w_wr_owns    = 1'b1;
            w_drain_done = w_fifo_empty && !r_pend;
         end
         c_st_handoff: begin
            w_frame_ready = 1'b1;
            w_rearm       = bus.host_done && bus.cap_continuous;
         end
         default: ;
      endcase
   end

   // ------------------------------------------------------ pixel packing
   assign w_last_pix = w_pix_acc && (r_x == c_x_last) && (r_y == c_y_last);

`ifdef MASK_WINDOW_EN
   logic w_in_mask;
   assign w_in_mask = (int'(r_x) >= MASK_X0) && (int'(r_x) <= MASK_X1) &&
                      (int'(r_y) >= MASK_Y0) && (int'(r_y) <= MASK_Y1);
   assign w_pix = w_in_mask ? 24'h000000 : bus.pix_data;
`else
   assign w_pix = bus.pix_data;
`endif

   assign w_new_word = r_p_odd ? {r_hold_b, w_pix[23:16]} : w_pix[23:8];

   always_ff @(posedge Main_CLK or posedge Reset) begin
      if (Reset) begin
         r_x         <= '0;
         r_y         <= '0;
         r_p_odd     <= 1'b0;
         r_hold_b    <= '0;
         r_pend      <= 1'b0;
         r_pend_word <= '0;
      end else begin
         if (w_start || w_short) begin
            r_x     <= '0;
            r_y     <= '0;
            r_p_odd <= 1'b0;
         end else if (w_pix_acc) begin
            r_p_odd <= ~r_p_odd;
            if (r_x == c_x_last) begin
               r_x <= '0;
               r_y <= (r_y == c_y_last) ? '0 : r_y + 1'b1;
            end else begin
               r_x <= r_x + 1'b1;
            end
         end
         if (w_pix_acc && !r_p_odd) r_hold_b <= w_pix[7:0];
         // Odd pixels emit their second word on the following cycle
         if (w_flush) begin
            r_pend <= 1'b0;
         end else if (w_pix_acc && r_p_odd) begin
            r_pend      <= 1'b1;
            r_pend_word <= w_pix[15:0];
         end else begin
            r_pend <= 1'b0;
         end
      end
   end

   // --------------------------------------------------------- word FIFO
   assign w_fifo_empty = (r_count == '0);
   assign w_flush      = w_start || w_short || w_arm_cap;
   assign w_space      = c_depth - r_count;
   assign w_acc_a      = r_pend && !w_flush && (w_space != '0);
   assign w_acc_b      = w_pix_acc && (w_space > (c_aw + 1)'(w_acc_a));
   assign w_drop       = (r_pend && !w_flush && !w_acc_a) || (w_pix_acc && !w_acc_b);
   assign w_pop        = !w_fifo_empty && !w_flush && w_wr_owns;

   always_ff @(posedge Main_CLK) begin
      if (w_acc_a) r_mem[r_wptr] <= r_pend_word;
      if (w_acc_b) r_mem[r_wptr + c_aw'(w_acc_a)] <= w_new_word;
   end

   always_ff @(posedge Main_CLK or posedge Reset) begin
      if (Reset) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else if (w_flush) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         r_wptr  <= r_wptr + c_aw'(w_acc_a) + c_aw'(w_acc_b);
         r_rptr  <= r_rptr + c_aw'(w_pop);
         r_count <= r_count + (c_aw + 1)'(w_acc_a) + (c_aw + 1)'(w_acc_b)
                    - (c_aw + 1)'(w_pop);
      end
   end

   // -------------------------------------------------------- write path
   assign w_slot_base = c_base + ADDR_W'(r_slot) * c_wpf;

   always_ff @(posedge Main_CLK or posedge Reset) begin
      if (Reset) begin
         r_word_cnt <= '0;
         r_wr_addr  <= '0;
         r_dq       <= '0;
         r_we_n     <= 1'b1;
      end else begin
         if (w_flush) begin
            r_word_cnt <= '0;
            r_we_n     <= 1'b1;
         end else if (w_pop) begin
            r_wr_addr  <= w_slot_base + r_word_cnt;
            r_dq       <= r_mem[r_rptr];
            r_we_n     <= 1'b0;
            r_word_cnt <= r_word_cnt + 1'b1;
         end else begin
            r_we_n     <= 1'b1;
         end
      end
   end

   // ------------------------------------------------ slots and status
   always_ff @(posedge Main_CLK or posedge Reset) begin
      if (Reset) begin
         r_slot       <= '0;
         r_ready_slot <= '0;
         r_overflow   <= 1'b0;
         r_short_err  <= 1'b0;
      end else begin
         if (w_arm_cap)    r_slot <= '0;
         else if (w_rearm) r_slot <= (r_slot == c_slot_last) ? 2'd0 : r_slot + 2'd1;
         if (w_drain_done) r_ready_slot <= r_slot;
         if (w_arm_cap)    r_overflow <= 1'b0;
         else if (w_drop)  r_overflow <= 1'b1;
         if (w_arm_cap)    r_short_err <= 1'b0;
         else if (w_short) r_short_err <= 1'b1;
      end
   end

   assign bus.sram_addr       = w_wr_owns ? r_wr_addr : bus.host_rd_addr;
   assign bus.sram_dq_out     = r_dq;
   assign bus.sram_we_n       = r_we_n;
   assign bus.sram_ce_n       = 1'b0;
   assign bus.sram_oe_n       = 1'b0;
   assign bus.sram_lb_n       = 1'b0;
   assign bus.sram_ub_n       = 1'b0;
   assign bus.cap_busy        = w_cap_busy;
   assign bus.frame_ready     = w_frame_ready;
   assign bus.ready_slot      = r_ready_slot;
   assign bus.overflow_err    = r_overflow;
   assign bus.short_frame_err = r_short_err;

endmodule

`default_nettype wire

// File: tb/tb_frame_capture_sram_ctrl.sv
// ============================================================================
// Module      : tb_frame_capture_sram_ctrl
// Description : Directed bench for frame_capture_sram_ctrl (4x2 frame, 2 slots).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_frame_capture_sram_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks   = 0;
   int   failures = 0;
   logic [35:0] wq[$];

   always #5 clk = ~clk;

   frame_capture_sram_ctrl_if #(.ADDR_W(20)) bus ();

   frame_capture_sram_ctrl #(
      .H_ACTIVE(4), .V_ACTIVE(2), .ADDR_W(20), .BASE_ADDR(0),
      .FRAME_SLOTS(2), .FIFO_DEPTH(4),
      .MASK_X0(1), .MASK_X1(2), .MASK_Y0(0), .MASK_Y1(0)
   ) dut (
      .Main_CLK(clk),
      .Reset(rst),
      .bus(bus)
   );

   always @(negedge clk)
      if (bus.sram_we_n === 1'b0) wq.push_back({bus.sram_addr, bus.sram_dq_out});

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Frame bytes run 1..24 in raster order, so word j = {2j+1, 2j+2}
   function automatic logic [7:0] exp_byte(input int b);
`ifdef MASK_WINDOW_EN
      if (b >= 4 && b <= 9) return 8'h00;
`endif
      return 8'(b);
   endfunction

   function automatic logic [15:0] exp_word(input int j);
      return {exp_byte(2 * j + 1), exp_byte(2 * j + 2)};
   endfunction

   task automatic send_frame(input int n, input int gap);
      for (int i = 0; i < n; i++) begin
         bus.pix_data  = {8'(3 * i + 1), 8'(3 * i + 2), 8'(3 * i + 3)};
         bus.pix_valid = 1'b1;
         step();
         bus.pix_valid = 1'b0;
         repeat (gap) step();
      end
   endtask

   task automatic pulse_req();
      bus.cap_req = 1'b1;
      step();
      bus.cap_req = 1'b0;
   endtask

   task automatic pulse_start();
      bus.frame_start = 1'b1;
      step();
      bus.frame_start = 1'b0;
   endtask

   task automatic pulse_done(input logic cont);
      bus.cap_continuous = cont;
      bus.host_done = 1'b1;
      step();
      bus.host_done = 1'b0;
   endtask

   task automatic wait_ready(input string tag);
      for (int i = 0; i < 40 && bus.frame_ready !== 1'b1; i++) step();
      check(tag, 32'(bus.frame_ready), 32'd1);
   endtask

   task automatic check_frame(input string tag, input int base);
      check({tag, "_nwords"}, 32'(wq.size()), 32'd12);
      for (int j = 0; j < 12; j++) begin
         if (j < wq.size()) begin
            check($sformatf("%s_addr%0d", tag, j), 32'(wq[j][35:16]), 32'(base + j));
            check($sformatf("%s_data%0d", tag, j), 32'(wq[j][15:0]), 32'(exp_word(j)));
         end
      end
   endtask

   initial begin
      bus.cap_req        = 1'b0;
      bus.cap_continuous = 1'b0;
      bus.frame_start    = 1'b0;
      bus.pix_valid      = 1'b0;
      bus.pix_data       = '0;
      bus.host_rd_addr   = 20'h12345;
      bus.host_done      = 1'b0;

      #1 rst = 1'b1;
      #1;
      check("rst_we_n", 32'(bus.sram_we_n), 32'd1);
      check("rst_ce_n", 32'(bus.sram_ce_n), 32'd0);
      check("rst_oe_n", 32'(bus.sram_oe_n), 32'd0);
      check("rst_lb_ub", 32'({bus.sram_lb_n, bus.sram_ub_n}), 32'd0);
      check("rst_addr", 32'(bus.sram_addr), 32'h12345);
      check("rst_dq", 32'(bus.sram_dq_out), 32'd0);
      check("rst_busy", 32'(bus.cap_busy), 32'd0);
      check("rst_ready", 32'(bus.frame_ready), 32'd0);
      check("rst_slot", 32'(bus.ready_slot), 32'd0);
      check("rst_errs", 32'({bus.overflow_err, bus.short_frame_err}), 32'd0);
      step();
      step();
      rst = 1'b0;
      step();

      // Single frame, one-shot
      pulse_req();
      check("armed_busy", 32'(bus.cap_busy), 32'd1);
      wq.delete();
      pulse_start();
      send_frame(8, 1);
      wait_ready("f1_ready");
      check_frame("f1", 0);
      check("f1_slot", 32'(bus.ready_slot), 32'd0);
      check("f1_busy", 32'(bus.cap_busy), 32'd0);
      bus.host_rd_addr = 20'h00abc;
      #1;
      check("f1_host_addr", 32'(bus.sram_addr), 32'h00abc);
      pulse_done(1'b0);
      check("f1_idle", 32'({bus.cap_busy, bus.frame_ready}), 32'd0);

      // Continuous ring over two slots, wrapping back to slot 0
      pulse_req();
      wq.delete();
      pulse_start();
      send_frame(8, 1);
      wait_ready("c0_ready");
      check_frame("c0", 0);
      check("c0_slot", 32'(bus.ready_slot), 32'd0);
      pulse_done(1'b1);
      check("c1_rearm", 32'(bus.cap_busy), 32'd1);
      wq.delete();
      pulse_start();
      send_frame(8, 1);
      wait_ready("c1_ready");
      check_frame("c1", 12);
      check("c1_slot", 32'(bus.ready_slot), 32'd1);
      pulse_done(1'b1);
      wq.delete();
      pulse_start();
      send_frame(8, 1);
      wait_ready("c2_ready");
      check_frame("c2", 0);
      check("c2_slot", 32'(bus.ready_slot), 32'd0);
      pulse_done(1'b0);

      // Early frame_start after 5 pixels
      pulse_req();
      pulse_start();
      send_frame(5, 1);
      repeat (4) step();
      check("sf_err_before", 32'(bus.short_frame_err), 32'd0);
      wq.delete();
      pulse_start();
      check("sf_err", 32'(bus.short_frame_err), 32'd1);
      check("sf_busy", 32'(bus.cap_busy), 32'd1);
      send_frame(8, 1);
      wait_ready("sf_ready");
      check_frame("sf", 0);
      check("sf_err_hold", 32'(bus.short_frame_err), 32'd1);
      pulse_done(1'b0);

      // Back-to-back pixels overrun the 4-entry FIFO
      pulse_req();
      check("ov_sf_cleared", 32'(bus.short_frame_err), 32'd0);
      pulse_start();
      send_frame(8, 0);
      check("ov_err", 32'(bus.overflow_err), 32'd1);
      wait_ready("ov_ready");
      check("ov_err_handoff", 32'(bus.overflow_err), 32'd1);
      pulse_done(1'b0);
      check("ov_err_idle", 32'(bus.overflow_err), 32'd1);
      pulse_req();
      check("ov_cleared", 32'(bus.overflow_err), 32'd0);

      // Reset while a write is on the pins
      pulse_start();
      bus.pix_data  = 24'hA1B2C3;
      bus.pix_valid = 1'b1;
      step();
      bus.pix_valid = 1'b0;
      step();
      check("rs_we_active", 32'(bus.sram_we_n), 32'd0);
      check("rs_wr_data", 32'(bus.sram_dq_out), 32'hA1B2);
      wq.delete();
      bus.host_rd_addr = 20'h54321;
      rst = 1'b1;
      #1;
      check("rs_we_n", 32'(bus.sram_we_n), 32'd1);
      check("rs_busy", 32'(bus.cap_busy), 32'd0);
      check("rs_addr", 32'(bus.sram_addr), 32'h54321);
      bus.pix_valid = 1'b1;
      repeat (3) step();
      bus.pix_valid = 1'b0;
      rst = 1'b0;
      repeat (4) step();
      check("rs_no_writes", 32'(wq.size()), 32'd0);
      check("rs_idle", 32'({bus.cap_busy, bus.frame_ready}), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
